// File: rtl/fetch_queue_pkg.sv
// Shared defaults and next-PC select encoding for the fetch queue.
package fetch_queue_pkg;

  localparam int          FQ_WIDTH    = 32;
  localparam logic [31:0] FQ_RESET_PC = 32'h0040_0020;
  localparam logic [31:0] FQ_PC_STEP  = 32'd4;
  localparam int          FQ_DEPTH    = 4;

  typedef enum logic [1:0] {
    PC_SEL_SEQ    = 2'd0,
    PC_SEL_BRANCH = 2'd1,
    PC_SEL_JR     = 2'd2,
    PC_SEL_J      = 2'd3
  } pc_sel_e;

  // Branch outranks any jump; jump_reg only qualifies a jump.
  function automatic pc_sel_e pc_select(input logic branch, input logic jump,
                                        input logic jump_reg);
    if (branch)
      return PC_SEL_BRANCH;
    else if (jump)
      return jump_reg ? PC_SEL_JR : PC_SEL_J;
    else
      return PC_SEL_SEQ;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Redirect, instruction-memory and decode-side signals of the fetch queue.
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int WIDTH = FQ_WIDTH
);
  logic             jump;
  logic             jump_reg;
  logic             branch;
  logic [WIDTH-1:0] branch_addr;
  logic [WIDTH-1:0] jump_reg_addr;
  logic [WIDTH-1:0] jump_addr;
  logic             imem_req_valid;
  logic             imem_req_ready;
  logic [WIDTH-1:0] imem_req_addr;
  logic             imem_resp_valid;
  logic [WIDTH-1:0] imem_resp_data;
  logic             decode_ready;
  logic             instr_valid;
  logic [WIDTH-1:0] instr;
  logic [WIDTH-1:0] pc_plus_4;

  // The fetch queue itself.
  modport master (
    input  jump, jump_reg, branch, branch_addr, jump_reg_addr, jump_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, decode_ready,
    output imem_req_valid, imem_req_addr, instr_valid, instr, pc_plus_4
  );

  // Memory, redirect logic and decode surrounding it.
  modport slave (
    output jump, jump_reg, branch, branch_addr, jump_reg_addr, jump_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data, decode_ready,
    input  imem_req_valid, imem_req_addr, instr_valid, instr, pc_plus_4
  );
endinterface

// File: rtl/fetch_queue_sync_fifo.sv
// Synchronous FIFO with flush; head is read combinationally from storage.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_flush,
  input  logic                   i_wr_en,
  input  logic [WIDTH-1:0]       i_wr_data,
  input  logic                   i_rd_en,
  output logic [WIDTH-1:0]       o_rd_data,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_wr;
  logic             w_rd;

  // A flush discards the same-cycle write; reads of an empty FIFO are ignored.
  assign w_wr = i_wr_en && !i_flush;
  assign w_rd = i_rd_en && !i_flush && (r_count != '0);

  // Pointer and occupancy control.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is data only and needs no reset.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_count   = r_count;

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: owns the PC, issues credit-limited pipelined imem requests,
// drops responses made stale by a redirect and queues the rest for decode.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int               WIDTH    = FQ_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(FQ_RESET_PC),
  parameter int               DEPTH    = FQ_DEPTH,
  parameter logic [WIDTH-1:0] PC_STEP  = WIDTH'(FQ_PC_STEP)
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.master ifc
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_fetch_pc;
  logic [CW-1:0]    r_outstanding;
  logic [CW-1:0]    r_drop;

  pc_sel_e          w_sel;
  logic             w_redirect;
  logic [WIDTH-1:0] w_next_pc;
  logic [CW:0]      w_inflight;
  logic             w_req_valid;
  logic             w_req_fire;
  logic             w_resp_fire;
  logic             w_resp_keep;
  logic             w_deq;
  logic             w_instr_valid;
  logic [CW-1:0]    w_outstanding_nxt;
  logic [CW-1:0]    w_icount;
  logic [CW-1:0]    w_acount;
  logic [WIDTH-1:0] w_ififo_data;
  logic [WIDTH-1:0] w_afifo_data;

  assign w_sel      = pc_select(ifc.branch, ifc.jump, ifc.jump_reg);
  assign w_redirect = ifc.branch | ifc.jump;

  // Outstanding requests reserve FIFO slots, so the FIFO can never overflow.
  assign w_inflight  = {1'b0, w_icount} + {1'b0, r_outstanding};
  assign w_req_valid = !reset && !w_redirect && (w_inflight < (CW+1)'(DEPTH));
  assign w_req_fire  = w_req_valid && ifc.imem_req_ready;
  assign w_resp_fire = ifc.imem_resp_valid;
  assign w_resp_keep = w_resp_fire && (r_drop == '0) && !w_redirect;

  // Decode is ignored in a redirect cycle: the head it sees is being flushed.
  assign w_instr_valid = (w_icount != '0);
  assign w_deq         = w_instr_valid && ifc.decode_ready && !w_redirect;

  assign w_outstanding_nxt = r_outstanding + CW'(w_req_fire) - CW'(w_resp_fire);

  // Next-PC mux: redirect targets, else sequential advance on acceptance.
  always_comb begin
    w_next_pc = r_fetch_pc;
    case (w_sel)
      PC_SEL_BRANCH: w_next_pc = ifc.branch_addr;
      PC_SEL_JR:     w_next_pc = ifc.jump_reg_addr;
      PC_SEL_J:      w_next_pc = ifc.jump_addr;
      default:       w_next_pc = w_req_fire ? r_fetch_pc + PC_STEP : r_fetch_pc;
    endcase
  end

  // PC, in-flight and drop bookkeeping; a redirect marks every request still
  // in flight after this cycle as stale.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else begin
      r_fetch_pc    <= w_next_pc;
      r_outstanding <= w_outstanding_nxt;
      if (w_redirect)
        r_drop <= w_outstanding_nxt;
      else if (w_resp_fire && (r_drop != '0))
        r_drop <= r_drop - CW'(1);
    end
  end

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_instr_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_flush   (w_redirect),
    .i_wr_en   (w_resp_keep),
    .i_wr_data (ifc.imem_resp_data),
    .i_rd_en   (w_deq),
    .o_rd_data (w_ififo_data),
    .o_count   (w_icount)
  );

  // Addresses are queued at acceptance, so after a flush only live requests
  // have entries and the head always pairs with the instruction head.
  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_addr_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_flush   (w_redirect),
    .i_wr_en   (w_req_fire),
    .i_wr_data (r_fetch_pc),
    .i_rd_en   (w_deq),
    .o_rd_data (w_afifo_data),
    .o_count   (w_acount)
  );

  // Protocol checks: no response without a request; address queue covers instructions.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (ifc.imem_resp_valid) assert (r_outstanding != '0);
      assert (w_acount >= w_icount);
    end
  end

  assign ifc.imem_req_valid = w_req_valid;
  assign ifc.imem_req_addr  = r_fetch_pc;
  assign ifc.instr_valid    = w_instr_valid;
  assign ifc.instr          = w_instr_valid ? w_ififo_data : '0;
  assign ifc.pc_plus_4      = w_instr_valid ? w_afifo_data + PC_STEP : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: in-order latency-L memory model, redirect table,
// and directed multi-cycle sequences.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0040_0020;
  localparam logic [31:0] BR_A   = 32'h0040_1000;
  localparam logic [31:0] JR_A   = 32'h0040_2000;
  localparam logic [31:0] J_A    = 32'h0040_3000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_queue_if #(.WIDTH(32)) ifc ();

  fetch_queue #(.WIDTH(32), .RESET_PC(RST_PC), .DEPTH(4), .PC_STEP(32'd4)) dut (
    .clk   (clk),
    .reset (reset),
    .ifc   (ifc.master)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_ent_t;

  typedef struct {
    bit          br;
    bit          j;
    bit          jr;
    bit          exp_rv;
    logic [31:0] exp_pc;
  } vec_t;

  mem_ent_t    mem_q[$];
  logic [31:0] acc_q[$];
  logic [31:0] drn_pc_q[$];
  logic [31:0] drn_ins_q[$];
  int          lat = 1;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  vec_t        tbl[6];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1234_5678;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // One clock: sample pre-edge handshakes, advance, update memory model and drive response.
  task automatic step();
    logic [31:0] a, ip, pp;
    bit rf, pf, df, rs;
    #1;
    rf = ifc.imem_req_valid && ifc.imem_req_ready;
    a  = ifc.imem_req_addr;
    pf = ifc.imem_resp_valid;
    df = ifc.instr_valid && ifc.decode_ready && !(ifc.branch || ifc.jump);
    ip = ifc.instr;
    pp = ifc.pc_plus_4;
    rs = reset;
    @(posedge clk);
    #1;
    cyc++;
    if (rs) begin
      mem_q.delete();
    end else begin
      if (pf && mem_q.size() > 0) void'(mem_q.pop_front());
      if (rf) begin
        mem_q.push_back('{a, cyc + lat - 1});
        acc_q.push_back(a);
      end
      if (df) begin
        drn_pc_q.push_back(pp);
        drn_ins_q.push_back(ip);
      end
    end
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      ifc.imem_resp_valid = 1'b1;
      ifc.imem_resp_data  = mem_word(mem_q[0].addr);
    end else begin
      ifc.imem_resp_valid = 1'b0;
      ifc.imem_resp_data  = 32'h0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ifc.branch = 1'b0; ifc.jump = 1'b0; ifc.jump_reg = 1'b0;
    ifc.decode_ready = 1'b0; ifc.imem_req_ready = 1'b0;
    step();
    step();
    chk("rst_instr_valid", 32'(ifc.instr_valid), 32'h0);
    chk("rst_req_valid", 32'(ifc.imem_req_valid), 32'h0);
    chk("rst_instr", ifc.instr, 32'h0);
    chk("rst_pc_plus_4", ifc.pc_plus_4, 32'h0);
    reset = 1'b0;
    mem_q.delete(); acc_q.delete(); drn_pc_q.delete(); drn_ins_q.delete();
    #1;
    chk("rst_req_addr", ifc.imem_req_addr, RST_PC);
    chk("rst_req_valid_after", 32'(ifc.imem_req_valid), 32'h1);
  endtask

  task automatic check_stream(input string tag, input logic [31:0] base);
    for (int i = 0; i < drn_pc_q.size(); i++) begin
      chk($sformatf("%s_pc%0d", tag, i), drn_pc_q[i], base + 32'(4 * (i + 1)));
      chk($sformatf("%s_ins%0d", tag, i), drn_ins_q[i], mem_word(base + 32'(4 * i)));
    end
  endtask

  task automatic run_until_drained(input string tag, input int n, input int budget);
    int b;
    b = budget;
    while (drn_pc_q.size() < n && b > 0) begin
      step();
      b--;
    end
    chk($sformatf("%s_drain_within_budget", tag), 32'(drn_pc_q.size() >= n), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    ifc.branch = 1'b0; ifc.jump = 1'b0; ifc.jump_reg = 1'b0;
    ifc.branch_addr = BR_A; ifc.jump_reg_addr = JR_A; ifc.jump_addr = J_A;
    ifc.imem_req_ready = 1'b0; ifc.imem_resp_valid = 1'b0; ifc.imem_resp_data = 32'h0;
    ifc.decode_ready = 1'b0;

    // Redirect priority table: memory never ready, so the PC only moves on redirect.
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, BR_A};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, BR_A};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, BR_A};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, JR_A};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, J_A};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b1, J_A};

    lat = 1;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      ifc.branch = tbl[i].br; ifc.jump = tbl[i].j; ifc.jump_reg = tbl[i].jr;
      #1;
      chk($sformatf("tbl%0d_req_valid", i), 32'(ifc.imem_req_valid), 32'(tbl[i].exp_rv));
      step();
      ifc.branch = 1'b0; ifc.jump = 1'b0; ifc.jump_reg = 1'b0;
      #1;
      chk($sformatf("tbl%0d_target", i), ifc.imem_req_addr, tbl[i].exp_pc);
      chk($sformatf("tbl%0d_req_valid_next", i), 32'(ifc.imem_req_valid), 32'h1);
    end

    // Streaming, latency 1, decode always ready.
    lat = 1;
    do_reset();
    ifc.imem_req_ready = 1'b1; ifc.decode_ready = 1'b1;
    step();
    chk("s1_valid_first", 32'(ifc.instr_valid), 32'h0);
    step();
    chk("s1_valid_second", 32'(ifc.instr_valid), 32'h1);
    chk("s1_head_pc4", ifc.pc_plus_4, 32'h0040_0024);
    chk("s1_head_instr", ifc.instr, mem_word(32'h0040_0020));
    repeat (10) step();
    chk("s1_throughput", 32'(drn_pc_q.size()), 32'd10);
    for (int i = 0; i < 4; i++)
      chk($sformatf("s1_req%0d", i), acc_q[i], RST_PC + 32'(4 * i));
    check_stream("s1", RST_PC);

    // Decode stalled: exactly DEPTH requests, then lossless drain.
    lat = 1;
    do_reset();
    ifc.imem_req_ready = 1'b1; ifc.decode_ready = 1'b0;
    repeat (10) step();
    chk("s2_accepted", 32'(acc_q.size()), 32'd4);
    chk("s2_req_blocked", 32'(ifc.imem_req_valid), 32'h0);
    chk("s2_head_valid", 32'(ifc.instr_valid), 32'h1);
    chk("s2_head_pc4", ifc.pc_plus_4, 32'h0040_0024);
    ifc.decode_ready = 1'b1;
    repeat (8) step();
    chk("s2_drained4", 32'(drn_pc_q.size() >= 4), 32'h1);
    check_stream("s2", RST_PC);

    // Branch with two requests in flight at latency 3.
    lat = 3;
    do_reset();
    ifc.imem_req_ready = 1'b1; ifc.decode_ready = 1'b1;
    step();
    step();
    chk("s3_in_flight", 32'(acc_q.size()), 32'd2);
    ifc.branch = 1'b1; ifc.branch_addr = 32'h0040_0100;
    #1;
    chk("s3_redirect_req_valid", 32'(ifc.imem_req_valid), 32'h0);
    step();
    ifc.branch = 1'b0;
    run_until_drained("s3", 1, 20);
    if (drn_pc_q.size() > 0) begin
      chk("s3_first_pc4", drn_pc_q[0], 32'h0040_0104);
      chk("s3_first_instr", drn_ins_q[0], mem_word(32'h0040_0100));
    end
    repeat (8) step();
    check_stream("s3", 32'h0040_0100);

    // Memory ready toggling randomly, decode toggling randomly.
    lat = 2;
    do_reset();
    for (int i = 0; i < 80; i++) begin
      ifc.imem_req_ready = 1'($urandom_range(0, 1));
      ifc.decode_ready   = 1'($urandom_range(0, 1));
      step();
    end
    ifc.imem_req_ready = 1'b1; ifc.decode_ready = 1'b1;
    repeat (10) step();
    for (int i = 0; i < acc_q.size(); i++)
      chk($sformatf("s4_req%0d", i), acc_q[i], RST_PC + 32'(4 * i));
    chk("s4_some_drained", 32'(drn_pc_q.size() > 10), 32'h1);
    check_stream("s4", RST_PC);

    // PC wraps modulo 2^32.
    lat = 1;
    do_reset();
    ifc.decode_ready = 1'b1;
    ifc.jump = 1'b1; ifc.jump_reg = 1'b0; ifc.jump_addr = 32'hFFFF_FFFC;
    step();
    ifc.jump = 1'b0; ifc.imem_req_ready = 1'b1;
    repeat (6) step();
    chk("s5_req0", acc_q[0], 32'hFFFF_FFFC);
    chk("s5_req1", acc_q[1], 32'h0000_0000);
    chk("s5_req2", acc_q[2], 32'h0000_0004);
    check_stream("s5", 32'hFFFF_FFFC);

    // Reset mid-stream with responses pending.
    lat = 3;
    do_reset();
    ifc.imem_req_ready = 1'b1; ifc.decode_ready = 1'b1;
    repeat (4) step();
    chk("s6_pending", 32'(mem_q.size() > 0), 32'h1);
    do_reset();
    ifc.imem_req_ready = 1'b1; ifc.decode_ready = 1'b0;
    repeat (8) step();
    chk("s6_credits_full", 32'(acc_q.size()), 32'd4);
    chk("s6_req_blocked", 32'(ifc.imem_req_valid), 32'h0);
    chk("s6_head_valid", 32'(ifc.instr_valid), 32'h1);
    chk("s6_head_pc4", ifc.pc_plus_4, RST_PC + 32'd4);
    chk("s6_head_instr", ifc.instr, mem_word(RST_PC));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
